// File: rtl/sha256_padder_if.sv
// Handshake bundle for the SHA-256 padder: word stream in, padded 512-bit blocks out.
interface sha256_padder_if;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_data;
   logic         in_last;
   logic [2:0]   in_bytes;
   logic         block_valid;
   logic         block_ready;
   logic [511:0] block;
   logic         block_first;
   logic         block_last;

   modport master (output in_valid, in_data, in_last, in_bytes, block_ready,
                   input  in_ready, block_valid, block, block_first, block_last);
   modport slave  (input  in_valid, in_data, in_last, in_bytes, block_ready,
                   output in_ready, block_valid, block, block_first, block_last);
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: 32-bit big-endian words in, FIPS 180-4 padded 512-bit blocks out.
// Optional macro SHA256_PAD_ERR_EN adds a sticky protocol-error output (err).
module sha256_padder #(
   parameter int LEN_W = 64
) (
   input  logic clk,
   input  logic reset,
`ifdef SHA256_PAD_ERR_EN
   output logic err,
`endif
   sha256_padder_if.slave bus
);
   typedef enum logic [1:0] {S_FILL, S_PAD, S_OUT} state_t;

   state_t           r_state, w_nxt;
   logic [4:0]       r_widx;
   logic [LEN_W-1:0] r_len;
   logic [31:0]      r_buf [16];
   logic             r_first, r_last, r_first_pending, r_pad_done, r_open;
   logic             w_acc, w_hs;
   logic [2:0]       w_k;
   logic [31:0]      w_pad_word;
   logic [63:0]      w_len64;

   assign w_acc   = bus.in_valid && (r_state == S_FILL);
   assign w_hs    = bus.block_ready && (r_state == S_OUT);
   assign w_len64 = 64'(r_len);

`ifdef SHA256_PAD_ERR_EN
   logic r_err, w_bad;
   assign w_bad = (bus.in_bytes > 3'd4) || ((bus.in_bytes != 3'd4) && !bus.in_last);
   assign w_k   = w_bad ? 3'd4 : bus.in_bytes;
   assign err   = r_err;
   always_ff @(posedge clk or posedge reset)
      if (reset)               r_err <= 1'b0;
      else if (w_acc && w_bad) r_err <= 1'b1;
`else
   assign w_k = (bus.in_bytes > 3'd4) ? 3'd4 : bus.in_bytes;
`endif

   // Final word: keep bytes below k, 0x80 at byte k, zeros after.
   always_comb begin
      w_pad_word = '0;
      for (int b = 0; b < 4; b++) begin
         if (3'(b) < w_k)       w_pad_word[31-8*b -: 8] = bus.in_data[31-8*b -: 8];
         else if (3'(b) == w_k) w_pad_word[31-8*b -: 8] = 8'h80;
      end
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) r_state <= S_FILL;
      else       r_state <= w_nxt;

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_FILL: if (w_acc) begin
            if (bus.in_last)           w_nxt = S_PAD;
            else if (r_widx == 5'd15)  w_nxt = S_OUT;
         end
         S_PAD: if (r_widx == 5'd16 || (r_pad_done && r_widx == 5'd14)) w_nxt = S_OUT;
         S_OUT: if (w_hs) w_nxt = (r_last || r_open) ? S_FILL : S_PAD;
         default: w_nxt = S_FILL;
      endcase
   end

   always_comb begin
      bus.in_ready    = (r_state == S_FILL);
      bus.block_valid = (r_state == S_OUT);
      bus.block_first = r_first;
      bus.block_last  = r_last;
      for (int i = 0; i < 16; i++) bus.block[511-32*i -: 32] = r_buf[i];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_widx          <= '0;
         r_len           <= '0;
         r_first         <= 1'b0;
         r_last          <= 1'b0;
         r_first_pending <= 1'b1;
         r_pad_done      <= 1'b0;
         r_open          <= 1'b1;
         for (int i = 0; i < 16; i++) r_buf[i] <= '0;
      end else begin
         case (r_state)
            S_FILL: if (w_acc) begin
               r_buf[r_widx[3:0]] <= bus.in_last ? w_pad_word : bus.in_data;
               r_len              <= r_len + LEN_W'({w_k, 3'b000});
               if (bus.in_last) begin
                  r_open     <= 1'b0;
                  r_pad_done <= (w_k != 3'd4);
                  r_widx     <= r_widx + 5'd1;
               end else begin
                  r_widx <= (r_widx == 5'd15) ? 5'd0 : r_widx + 5'd1;
               end
            end
            S_PAD: begin
               if (r_widx == 5'd16) begin
                  r_widx <= '0;
               end else if (!r_pad_done) begin
                  r_buf[r_widx[3:0]] <= 32'h8000_0000;
                  r_pad_done         <= 1'b1;
                  r_widx             <= r_widx + 5'd1;
               end else if (r_widx == 5'd14) begin
                  r_buf[14] <= w_len64[63:32];
                  r_buf[15] <= w_len64[31:0];
                  r_widx    <= '0;
               end else begin
                  r_buf[r_widx[3:0]] <= '0;
                  r_widx             <= r_widx + 5'd1;
               end
            end
            S_OUT: if (w_hs) begin
               for (int i = 0; i < 16; i++) r_buf[i] <= '0;
               r_first_pending <= r_last;
               if (r_last) begin
                  r_len  <= '0;
                  r_open <= 1'b1;
               end
            end
            default: ;
         endcase
         // Flags are latched once on OUT entry so they stay stable under backpressure.
         if (r_state != S_OUT && w_nxt == S_OUT) begin
            r_first <= r_first_pending;
            r_last  <= (r_state == S_PAD) && r_pad_done && (r_widx == 5'd14);
         end
      end
   end
endmodule
